prbs10_checker: RTL

PRBS10_CHECKER -- requirements
Module: prbs10_checker

---
 rtl/prbs10_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/prbs10_checker.sv
// prbs10_checker: locks onto the 10-bit XNOR PRBS s[n+10] = ~(s[n+3]^s[n])
// received on in_bit, flywheels the sequence once locked and reports bit
// errors as a one-cycle pulse plus a saturating error count.
// Optional feature macro: PRBS10_ERR_COUNT_EN builds the error counter and
// honours err_clr; without it err_count is tied to zero.
module prbs10_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        err_clr,
    output logic        lock,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] LOCK_TGT = LOCK_CNT[7:0];
    localparam logic [3:0] LOSS_TGT = LOSS_CNT[3:0];

    logic [1:0] state_q, state_d;
    logic [9:0] hist_q, hist_d;
    logic [3:0] fill_cnt_q, fill_cnt_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic       lock_q, lock_d;
    logic       err_pulse_q, err_pulse_d;
    logic       count_inc;
    logic       predicted;
    logic [9:0] shifted_in;

    // Next-state logic: fill the history, verify predictions, then flywheel while locked.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        lock_d      = lock_q;
        err_pulse_d = 1'b0;
        count_inc   = 1'b0;
        predicted   = ~(hist_q[3] ^ hist_q[0]);
        shifted_in  = {in_bit, hist_q[9:1]};
        if (in_valid) begin
            case (state_q)
                ST_FILL: begin
                    hist_d = shifted_in;
                    if (fill_cnt_q == 4'd9) begin
                        fill_cnt_d = 4'd0;
                        if (shifted_in != 10'h3FF) begin
                            state_d     = ST_VERIFY;
                            match_cnt_d = 8'd0;
                        end
                    end else begin
                        fill_cnt_d = fill_cnt_q + 4'd1;
                    end
                end
                ST_VERIFY: begin
                    hist_d = shifted_in;
                    if (in_bit == predicted) begin
                        if (match_cnt_q + 8'd1 == LOCK_TGT) begin
                            state_d     = ST_LOCKED;
                            lock_d      = 1'b1;
                            match_cnt_d = 8'd0;
                            miss_cnt_d  = 4'd0;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d     = ST_FILL;
                        fill_cnt_d  = 4'd1;
                        match_cnt_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    hist_d = {predicted, hist_q[9:1]};
                    if (in_bit != predicted) begin
                        err_pulse_d = 1'b1;
                        count_inc   = 1'b1;
                        if (miss_cnt_q + 4'd1 == LOSS_TGT) begin
                            state_d    = ST_FILL;
                            fill_cnt_d = 4'd0;
                            miss_cnt_d = 4'd0;
                            lock_d     = 1'b0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end else begin
                        miss_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d    = ST_FILL;
                    fill_cnt_d = 4'd0;
                    lock_d     = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset drops all history so lock must be re-earned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FILL;
            hist_q      <= 10'd0;
            fill_cnt_q  <= 4'd0;
            match_cnt_q <= 8'd0;
            miss_cnt_q  <= 4'd0;
            lock_q      <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            lock_q      <= lock_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign lock      = lock_q;
    assign err_pulse = err_pulse_q;

`ifdef PRBS10_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Error counter: clear wins over the old value but still counts a same-cycle error.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = count_inc ? 16'd1 : 16'd0;
        end else if (count_inc && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    // No counter: err_count is constant zero and err_clr has no effect.
    assign err_count = {16{(err_clr | count_inc) & 1'b0}};
`endif

endmodule
